// File: rtl/match_sequencer.sv
// Pong game sequencer: frame divider, serve/rally/point/game-over FSM, score keeping,
// and the load/step strobes that drive the ball-physics block.
module match_sequencer #(
  parameter int FRAME_DIV    = 833333,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 11,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               pause_i,
  input  logic [1:0]         player_did_score,
  output logic               frame_tick,
  output logic               phys_step,
  output logic               phys_load,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic [2:0]         state_o,
  output logic               game_over,
  output logic               winner
);

  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int SRV_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(FRAME_DIV - 1);
  localparam logic [SRV_W-1:0]   SRV_LOAD = SRV_W'(SERVE_FRAMES);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] frame_cnt;
  logic [SRV_W-1:0] serve_cnt;

  // The divider free-runs in every state so frame timing never depends on pause or game flow.
  always_ff @(posedge clk) begin
    // NOTE: reset here is synchronous (sampled on the clock edge), and all sequential
    // state uses non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      frame_cnt <= '0;
    end else if (frame_cnt == CNT_MAX) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  assign frame_tick = (frame_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      serve_cnt   <= '0;
      score_left  <= '0;
      score_right <= '0;
      serve_dir   <= 1'b0;
      winner      <= 1'b0;
      phys_load   <= 1'b0;
    end else begin
      phys_load <= 1'b0;
      case (state)
        IDLE, GAME_OVER: begin
          if (start_i) begin
            score_left  <= '0;
            score_right <= '0;
            serve_dir   <= 1'b0;
            phys_load   <= 1'b1;
            serve_cnt   <= SRV_LOAD;
            state       <= SERVE;
          end
        end

        SERVE: begin
          if (frame_tick && !pause_i) begin
            if (serve_cnt == SRV_W'(1)) begin
              state <= PLAY;
            end else begin
              serve_cnt <= serve_cnt - SRV_W'(1);
            end
          end
        end

        PLAY: begin
          // Scoring exits the rally even while paused; 2'b11 is a void rally.
          if (player_did_score != 2'b00) begin
            state <= POINT;
            case (player_did_score)
              2'b01: begin
                score_left <= score_left + SCORE_W'(1);
                serve_dir  <= 1'b1;
              end
              2'b10: begin
                score_right <= score_right + SCORE_W'(1);
                serve_dir   <= 1'b0;
              end
              default: ;
            endcase
          end
        end

        POINT: begin
          if (score_left == WIN) begin
            winner <= 1'b0;
            state  <= GAME_OVER;
          end else if (score_right == WIN) begin
            winner <= 1'b1;
            state  <= GAME_OVER;
          end else begin
            phys_load <= 1'b1;
            serve_cnt <= SRV_LOAD;
            state     <= SERVE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign phys_step = (state == PLAY) && frame_tick && !pause_i;
  assign game_over = (state == GAME_OVER);
  assign state_o   = state;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer: expectations are queued as stimulus is driven
// and popped/compared after the clock edge that should produce them.
module tb_match_sequencer;

  localparam int FRAME_DIV    = 4;
  localparam int SERVE_FRAMES = 2;
  localparam int WIN_SCORE    = 3;
  localparam int SCORE_W      = 4;

  localparam int ST_IDLE = 0, ST_SERVE = 1, ST_PLAY = 2, ST_POINT = 3, ST_OVER = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start_i;
  logic               pause_i;
  logic [1:0]         player_did_score;
  logic               frame_tick;
  logic               phys_step;
  logic               phys_load;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  logic [2:0]         state_o;
  logic               game_over;
  logic               winner;

  match_sequencer #(
    .FRAME_DIV   (FRAME_DIV),
    .SERVE_FRAMES(SERVE_FRAMES),
    .WIN_SCORE   (WIN_SCORE),
    .SCORE_W     (SCORE_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .pause_i         (pause_i),
    .player_did_score(player_did_score),
    .frame_tick      (frame_tick),
    .phys_step       (phys_step),
    .phys_load       (phys_load),
    .serve_dir       (serve_dir),
    .score_left      (score_left),
    .score_right     (score_right),
    .state_o         (state_o),
    .game_over       (game_over),
    .winner          (winner)
  );

  always #5 clk = ~clk;

  typedef enum {SIG_STATE, SIG_SL, SIG_SR, SIG_DIR, SIG_LOAD, SIG_STEP, SIG_TICK, SIG_GO, SIG_WIN} sig_e;
  typedef struct {
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;  // cycles since the last edge that saw rst high

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      SIG_STATE: return 32'(state_o);
      SIG_SL:    return 32'(score_left);
      SIG_SR:    return 32'(score_right);
      SIG_DIR:   return 32'(serve_dir);
      SIG_LOAD:  return 32'(phys_load);
      SIG_STEP:  return 32'(phys_step);
      SIG_TICK:  return 32'(frame_tick);
      SIG_GO:    return 32'(game_over);
      SIG_WIN:   return 32'(winner);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  task automatic exp_(input sig_e s, input int v);
    exp_t e;
    e.sig = s;
    e.val = 32'(v);
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s at cyc %0d: observed=%0d expected=%0d", e.sig.name(), cyc, obs, e.val);
      end
    end
  endtask

  // One clock edge; the divider is modelled independently as cyc mod FRAME_DIV.
  task automatic step();
    @(posedge clk);
    #1;
    cyc = rst ? 0 : cyc + 1;
    exp_(SIG_TICK, int'((cyc % FRAME_DIV) == FRAME_DIV - 1));
    check();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; pause_i = 1'b0; player_did_score = 2'b00;
    repeat (3) step();
    rst = 1'b0;

    // Reset values
    exp_(SIG_STATE, ST_IDLE); exp_(SIG_SL, 0); exp_(SIG_SR, 0); exp_(SIG_DIR, 0);
    exp_(SIG_WIN, 0); exp_(SIG_LOAD, 0); exp_(SIG_STEP, 0); exp_(SIG_GO, 0);
    check();

    // Divider ticks at 3, 7, 11 are checked on every step
    run_to(11);

    // Serve: start -> SERVE with load and dir 0
    start_i = 1'b1;
    exp_(SIG_STATE, ST_SERVE); exp_(SIG_LOAD, 1); exp_(SIG_DIR, 0);
    step();
    start_i = 1'b0;
    exp_(SIG_LOAD, 0);
    step();
    run_to(19);
    exp_(SIG_STATE, ST_SERVE); exp_(SIG_STEP, 0);
    check();
    exp_(SIG_STATE, ST_PLAY);
    step();
    run_to(22);
    exp_(SIG_STEP, 0);
    check();
    exp_(SIG_STEP, 1);
    step();

    // Left point
    step();
    player_did_score = 2'b01;
    exp_(SIG_STATE, ST_POINT); exp_(SIG_SL, 1); exp_(SIG_SR, 0); exp_(SIG_DIR, 1); exp_(SIG_LOAD, 0);
    step();
    exp_(SIG_STATE, ST_SERVE); exp_(SIG_LOAD, 1); exp_(SIG_DIR, 1);
    step();
    player_did_score = 2'b00;
    run_to(32);
    exp_(SIG_STATE, ST_PLAY);
    check();

    // Right point
    player_did_score = 2'b10;
    exp_(SIG_STATE, ST_POINT); exp_(SIG_SL, 1); exp_(SIG_SR, 1); exp_(SIG_DIR, 0);
    step();
    exp_(SIG_STATE, ST_SERVE); exp_(SIG_LOAD, 1); exp_(SIG_DIR, 0);
    step();
    player_did_score = 2'b00;

    // Pause across ticks 35, 39, 43: PLAY moves from cycle 40 to 52
    pause_i = 1'b1;
    run_to(44);
    pause_i = 1'b0;
    run_to(48);
    exp_(SIG_STATE, ST_SERVE);
    check();
    run_to(51);
    exp_(SIG_STATE, ST_SERVE);
    check();
    exp_(SIG_STATE, ST_PLAY);
    step();

    // Pause in PLAY: no step on tick 55; score while paused still reaches POINT
    pause_i = 1'b1;
    run_to(55);
    exp_(SIG_STEP, 0); exp_(SIG_STATE, ST_PLAY);
    check();
    step();
    player_did_score = 2'b01;
    exp_(SIG_STATE, ST_POINT); exp_(SIG_SL, 2); exp_(SIG_DIR, 1);
    step();
    pause_i = 1'b0;
    exp_(SIG_STATE, ST_SERVE); exp_(SIG_LOAD, 1);
    step();
    player_did_score = 2'b00;
    run_to(64);
    exp_(SIG_STATE, ST_PLAY);
    check();

    // Void rally
    player_did_score = 2'b11;
    exp_(SIG_STATE, ST_POINT); exp_(SIG_SL, 2); exp_(SIG_SR, 1); exp_(SIG_DIR, 1);
    step();
    exp_(SIG_STATE, ST_SERVE); exp_(SIG_LOAD, 1); exp_(SIG_DIR, 1);
    step();
    player_did_score = 2'b00;
    run_to(72);
    exp_(SIG_STATE, ST_PLAY);
    check();

    // Third left point wins the game
    player_did_score = 2'b01;
    exp_(SIG_STATE, ST_POINT); exp_(SIG_SL, 3);
    step();
    exp_(SIG_STATE, ST_OVER); exp_(SIG_GO, 1); exp_(SIG_WIN, 0); exp_(SIG_LOAD, 0);
    exp_(SIG_SL, 3); exp_(SIG_SR, 1);
    step();
    exp_(SIG_STEP, 0); exp_(SIG_STATE, ST_OVER);
    step();
    exp_(SIG_SL, 3); exp_(SIG_GO, 1);
    step();

    // Restart from GAME_OVER
    player_did_score = 2'b00;
    start_i = 1'b1;
    exp_(SIG_STATE, ST_SERVE); exp_(SIG_SL, 0); exp_(SIG_SR, 0); exp_(SIG_DIR, 0);
    exp_(SIG_LOAD, 1); exp_(SIG_GO, 0);
    step();
    start_i = 1'b0;

    // Two right points, then reset mid-rally
    run_to(84);
    exp_(SIG_STATE, ST_PLAY);
    check();
    player_did_score = 2'b10;
    step();
    player_did_score = 2'b00;
    step();
    run_to(92);
    player_did_score = 2'b10;
    step();
    player_did_score = 2'b00;
    step();
    run_to(100);
    exp_(SIG_STATE, ST_PLAY); exp_(SIG_SR, 2); exp_(SIG_SL, 0);
    check();

    rst = 1'b1;
    start_i = 1'b1;
    exp_(SIG_STATE, ST_IDLE); exp_(SIG_SL, 0); exp_(SIG_SR, 0); exp_(SIG_DIR, 0);
    exp_(SIG_LOAD, 0); exp_(SIG_STEP, 0); exp_(SIG_GO, 0);
    step();
    start_i = 1'b0;
    rst = 1'b0;
    exp_(SIG_STATE, ST_IDLE); exp_(SIG_LOAD, 0); exp_(SIG_STEP, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
